// File: rtl/serial_sub_4bit.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^N), one bit per clock, LSB first,
// through a single full-subtractor cell, bracketed by a start/busy/done handshake.
module serial_sub_4bit #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   p_sh;
  logic           br;
  logic [CW-1:0]  cnt;

  logic           d_c;
  logic           br_nxt_c;
  logic [N-1:0]   p_nxt_c;
  logic           accept_c;

  // Full-subtractor cell on the current LSBs plus the borrow register
  always_comb begin
    d_c      = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt_c = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);
    p_nxt_c  = {d_c, p_sh[N-1:1]};
    accept_c = start && ((state == ST_IDLE) || (state == ST_DONE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      p_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_c) begin
        // Accept from IDLE or straight out of DONE for back-to-back operation
        a_sh  <= a;
        b_sh  <= b;
        br    <= bin;
        p_sh  <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
        state <= ST_SHIFT;
      end else begin
        unique case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_SHIFT: begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            br   <= br_nxt_c;
            p_sh <= p_nxt_c;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
              diff  <= p_nxt_c;
              bout  <= br_nxt_c;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
